// File: rtl/phy_rx_deserializer.sv
// Serial-to-4-lane receive deserializer: locks byte alignment on consecutive COM
// characters, then rebuilds lanes 0..3 and presents one registered word per 32 bits.
module phy_rx_deserializer #(
    parameter logic [7:0] COM       = 8'hBC,
    parameter int         ALIGN_CNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_0,
    output logic [7:0] data_1,
    output logic [7:0] data_2,
    output logic [7:0] data_3,
    output logic       valid_0,
    output logic       valid_1,
    output logic       valid_2,
    output logic       valid_3,
    output logic       out_stb,
    output logic       active
);

    typedef enum logic [1:0] {SEARCH, LOCK, ACTIVE} state_t;

    localparam int            CW         = $clog2(ALIGN_CNT + 1);
    localparam logic [CW-1:0] ALIGN_LAST = CW'(ALIGN_CNT - 1);

    state_t        r_state;
    logic [7:0]    r_sh;
    logic [2:0]    r_bit_cnt;
    logic [CW-1:0] r_com_cnt;
    logic [1:0]    r_lane_idx;
    logic [7:0]    r_buf_0, r_buf_1, r_buf_2;
    logic [7:0]    r_data [4];
    logic [3:0]    r_valid;
    logic          r_out_stb;
    logic          r_active;

    logic [7:0]    w_nxt;
    logic [7:0]    w_lane [4];

    // The byte completing on this edge already includes the bit being sampled now.
    assign w_nxt = {r_sh[6:0], data_in};

    assign w_lane[0] = r_buf_0;
    assign w_lane[1] = r_buf_1;
    assign w_lane[2] = r_buf_2;
    assign w_lane[3] = w_nxt;

    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            // NOTE: the lane buffers are tiny and reset alongside the control state,
            // so a mid-frame reset can never leak stale bytes into a later frame.
            r_state    <= SEARCH;
            r_sh       <= '0;
            r_bit_cnt  <= '0;
            r_com_cnt  <= '0;
            r_lane_idx <= '0;
            r_buf_0    <= '0;
            r_buf_1    <= '0;
            r_buf_2    <= '0;
            for (int k = 0; k < 4; k++) r_data[k] <= '0;
            r_valid    <= '0;
            r_out_stb  <= 1'b0;
            r_active   <= 1'b0;
        end else begin
            r_sh      <= w_nxt;
            r_out_stb <= 1'b0;
            case (r_state)
                SEARCH: begin
                    if (w_nxt == COM) begin
                        r_state   <= LOCK;
                        r_com_cnt <= CW'(1);
                        r_bit_cnt <= '0;
                    end
                end
                LOCK: begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        if (w_nxt == COM) begin
                            r_com_cnt <= r_com_cnt + CW'(1);
                            if (r_com_cnt == ALIGN_LAST) begin
                                r_state    <= ACTIVE;
                                r_active   <= 1'b1;
                                r_lane_idx <= '0;
                                r_bit_cnt  <= '0;
                            end
                        end else begin
                            r_state   <= SEARCH;
                            r_com_cnt <= '0;
                        end
                    end
                end
                ACTIVE: begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_lane_idx <= r_lane_idx + 2'd1;
                        case (r_lane_idx)
                            2'd0: r_buf_0 <= w_nxt;
                            2'd1: r_buf_1 <= w_nxt;
                            2'd2: r_buf_2 <= w_nxt;
                            default: begin
                                // A COM in any slot means that lane carried no data.
                                for (int k = 0; k < 4; k++) begin
                                    if (w_lane[k] == COM) begin
                                        r_data[k]  <= 8'h00;
                                        r_valid[k] <= 1'b0;
                                    end else begin
                                        r_data[k]  <= w_lane[k];
                                        r_valid[k] <= 1'b1;
                                    end
                                end
                                r_out_stb <= 1'b1;
                            end
                        endcase
                    end
                end
                default: r_state <= SEARCH;
            endcase
        end
    end

    assign data_0  = r_data[0];
    assign data_1  = r_data[1];
    assign data_2  = r_data[2];
    assign data_3  = r_data[3];
    assign valid_0 = r_valid[0];
    assign valid_1 = r_valid[1];
    assign valid_2 = r_valid[2];
    assign valid_3 = r_valid[3];
    assign out_stb = r_out_stb;
    assign active  = r_active;

endmodule

// File: tb/tb_phy_rx_deserializer.sv
// Directed bench for phy_rx_deserializer: alignment, frame decode, false lock,
// idle cadence and mid-frame reset, with hand-computed expectations.
module tb_phy_rx_deserializer;

    localparam logic [7:0] COM = 8'hBC;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_0, data_1, data_2, data_3;
    logic       valid_0, valid_1, valid_2, valid_3;
    logic       out_stb, active;

    int n_checks    = 0;
    int n_pass      = 0;
    int cyc         = 0;
    int stb_count   = 0;
    int last_stb    = 0;
    int stb_period  = 0;

    phy_rx_deserializer #(.COM(COM), .ALIGN_CNT(4)) dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .data_in (data_in),
        .data_0  (data_0),
        .data_1  (data_1),
        .data_2  (data_2),
        .data_3  (data_3),
        .valid_0 (valid_0),
        .valid_1 (valid_1),
        .valid_2 (valid_2),
        .valid_3 (valid_3),
        .out_stb (out_stb),
        .active  (active)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Drive one bit, then sample outputs 1 ns after the edge that consumed it.
    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
        cyc++;
        if (out_stb === 1'b1) begin
            stb_count++;
            stb_period = cyc - last_stb;
            last_stb   = cyc;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic check_outs(input string tag, input logic [31:0] exp_data,
                              input logic [3:0] exp_valid, input logic exp_stb,
                              input logic exp_act);
        check({tag, ".data"},   {data_3, data_2, data_1, data_0}, exp_data);
        check({tag, ".valid"},  {28'd0, valid_3, valid_2, valid_1, valid_0}, {28'd0, exp_valid});
        check({tag, ".stb"},    {31'd0, out_stb}, {31'd0, exp_stb});
        check({tag, ".active"}, {31'd0, active},  {31'd0, exp_act});
    endtask

    task automatic align4(input string tag);
        for (int i = 0; i < 3; i++) send_byte(COM);
        for (int i = 7; i >= 1; i--) send_bit(COM[i]);
        check({tag, ".pre_active"}, {31'd0, active}, 32'd0);
        send_bit(COM[0]);
        check({tag, ".active"}, {31'd0, active}, 32'd1);
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] last;
        last = b3;
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        for (int i = 7; i >= 1; i--) send_bit(last[i]);
        check("frame.pre_stb", {31'd0, out_stb}, 32'd0);
        send_bit(last[0]);
    endtask

    initial begin
        // Reset held while data toggles
        reset = 1'b0;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check_outs("reset", 32'h0, 4'h0, 1'b0, 1'b0);
        reset = 1'b1;

        // Junk bits then four COMs
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check_outs("junk", 32'h0, 4'h0, 1'b0, 1'b0);
        align4("align");
        check("align.no_stb", stb_count, 32'd0);
        check_outs("align.outs", 32'h0, 4'h0, 1'b0, 1'b1);

        // First data frame: COM in lane 2
        send_frame(8'hFF, 8'h01, COM, 8'h7A);
        check_outs("frame1", 32'h7A0001FF, 4'b1011, 1'b1, 1'b1);
        check("frame1.stb_count", stb_count, 32'd1);

        // Continuous idle: strobe every 32 bits, all lanes not valid
        for (int f = 0; f < 4; f++) begin
            send_byte(COM);
            if (f == 0) check_outs("idle.hold", 32'h7A0001FF, 4'b1011, 1'b0, 1'b1);
            send_byte(COM);
            send_byte(COM);
            send_byte(COM);
            check_outs($sformatf("idle%0d", f), 32'h0, 4'h0, 1'b1, 1'b1);
            check($sformatf("idle%0d.period", f), stb_period, 32'd32);
            check($sformatf("idle%0d.count", f), stb_count, 32'(2 + f));
        end

        // False lock: two COMs then a non-COM byte drops back to SEARCH
        reset = 1'b0;
        send_bit(1'b0);
        reset = 1'b1;
        check_outs("rst2", 32'h0, 4'h0, 1'b0, 1'b0);
        send_byte(COM);
        send_byte(COM);
        send_byte(8'h12);
        check("false.active", {31'd0, active}, 32'd0);
        align4("relock");
        send_frame(8'h11, 8'h22, 8'h33, COM);
        check_outs("frame2", 32'h00332211, 4'b0111, 1'b1, 1'b1);

        // Reset at bit 13 of a frame, then realign
        send_byte(8'hA5);
        for (int i = 7; i >= 3; i--) send_bit(1'b0);
        reset = 1'b0;
        send_bit(1'b1);
        check_outs("midrst", 32'h0, 4'h0, 1'b0, 1'b0);
        reset = 1'b1;
        align4("realign");
        send_frame(8'h3C, 8'hC3, 8'h00, 8'h81);
        check_outs("frame3", 32'h8100C33C, 4'b1111, 1'b1, 1'b1);
        send_bit(1'b1);
        check("frame3.stb_drop", {31'd0, out_stb}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
